// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Imported by the loader top and its word assembler.
package prog_loader_pkg;

    localparam int unsigned WordWidth       = 32;
    localparam int unsigned AddrWidth       = 8;
    localparam logic [7:0]  SyncByteDefault = 8'hA5;

    typedef logic [WordWidth-1:0] word_t;
    typedef logic [AddrWidth-1:0] addr_t;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StRelease,
        StRun
    } state_e;

    typedef struct packed {
        logic cpu_reset;
        logic prog_mode;
        logic busy;
    } core_ctrl_t;

    // Core control lines are a pure function of the loader state.
    function automatic core_ctrl_t state_ctrl(input state_e st);
        core_ctrl_t c;
        c.cpu_reset = 1'b1;
        c.prog_mode = 1'b0;
        c.busy      = 1'b0;
        case (st)
            StHdr, StData: c.busy = 1'b1;
            StRelease:     c.prog_mode = 1'b1;
            StRun: begin
                c.cpu_reset = 1'b0;
                c.prog_mode = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/prog_word_pack.sv
// Four-byte MSB-first word assembler; pulses o_word_valid for one cycle
// after the 4th byte of each word has been shifted in.
module prog_word_pack
    import prog_loader_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clr,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output word_t      o_word,
    output logic       o_word_valid
);

    word_t      r_shift;
    logic [1:0] r_byte_cnt;
    logic       r_word_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_shift      <= '0;
            r_byte_cnt   <= 2'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_valid) begin
                r_shift      <= {r_shift[WordWidth-9:0], i_byte};
                r_byte_cnt   <= r_byte_cnt + 2'd1;
                r_word_valid <= (r_byte_cnt == 2'd3);
            end
        end
    end

    assign o_word       = r_shift;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/prog_loader.sv
// UART byte-stream loader: frames SYNC, count, big-endian words into the
// core's instruction-memory programming port, then releases the core.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE  = SyncByteDefault,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned RST_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    output logic       o_ProgMode,
    output logic       o_cpu_reset,
    output addr_t      o_Addr_Prog,
    output word_t      o_Data_Prog,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);

    localparam int unsigned TimeoutW = $clog2(TIMEOUT + 1);
    localparam int unsigned RelW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT - 1);
    localparam logic [RelW-1:0]     RelLast     = RelW'(RST_CYCLES - 1);

    state_e              r_state,    w_state_next;
    logic [TimeoutW-1:0] r_idle_cnt, w_idle_cnt_next;
    logic [RelW-1:0]     r_rel_cnt,  w_rel_cnt_next;
    addr_t               r_count,    w_count_next;
    addr_t               r_word_idx, w_word_idx_next;
    addr_t               r_addr,     w_addr_next;
    word_t               r_data,     w_data_next;
    logic                r_error,    w_error_next;
    logic                r_done,     w_done_next;

    logic       w_sync;
    logic       w_pack_clr;
    word_t      w_word;
    logic       w_word_valid;
    core_ctrl_t w_ctrl;

    assign w_sync     = i_rx_valid && (i_rx_byte == SYNC_BYTE);
    assign w_pack_clr = (r_state != StData);

    prog_word_pack u_word_pack (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clr        (w_pack_clr),
        .i_valid      (i_rx_valid),
        .i_byte       (i_rx_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_state_next    = r_state;
        w_idle_cnt_next = r_idle_cnt;
        w_rel_cnt_next  = r_rel_cnt;
        w_count_next    = r_count;
        w_word_idx_next = r_word_idx;
        w_addr_next     = r_addr;
        w_data_next     = r_data;
        w_error_next    = r_error;
        w_done_next     = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_sync) begin
                    w_state_next    = StHdr;
                    w_error_next    = 1'b0;
                    w_idle_cnt_next = '0;
                end
            end
            StHdr: begin
                if (i_rx_valid) begin
                    w_count_next    = i_rx_byte;
                    w_word_idx_next = '0;
                    w_idle_cnt_next = '0;
                    w_state_next    = StData;
                end else if (r_idle_cnt == TimeoutLast) begin
                    w_state_next = StIdle;
                    w_error_next = 1'b1;
                end else begin
                    w_idle_cnt_next = r_idle_cnt + TimeoutW'(1);
                end
            end
            StData: begin
                // Address and data are committed together, one edge after the 4th byte.
                if (w_word_valid) begin
                    w_addr_next = r_word_idx;
                    w_data_next = w_word;
                    if (r_word_idx == r_count) begin
                        w_state_next   = StRelease;
                        w_rel_cnt_next = '0;
                    end else begin
                        w_word_idx_next = r_word_idx + addr_t'(1);
                    end
                end
                if (i_rx_valid) begin
                    w_idle_cnt_next = '0;
                end else if ((r_idle_cnt == TimeoutLast) && !w_word_valid) begin
                    w_state_next = StIdle;
                    w_error_next = 1'b1;
                end else begin
                    w_idle_cnt_next = r_idle_cnt + TimeoutW'(1);
                end
            end
            StRelease: begin
                if (r_rel_cnt == RelLast) begin
                    w_state_next = StRun;
                    w_done_next  = 1'b1;
                end else begin
                    w_rel_cnt_next = r_rel_cnt + RelW'(1);
                end
            end
            StRun: begin
                if (w_sync) begin
                    w_state_next    = StHdr;
                    w_error_next    = 1'b0;
                    w_idle_cnt_next = '0;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_idle_cnt <= '0;
            r_rel_cnt  <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idle_cnt <= w_idle_cnt_next;
            r_rel_cnt  <= w_rel_cnt_next;
            r_count    <= w_count_next;
            r_word_idx <= w_word_idx_next;
            r_addr     <= w_addr_next;
            r_data     <= w_data_next;
            r_error    <= w_error_next;
            r_done     <= w_done_next;
        end
    end

    assign w_ctrl      = state_ctrl(r_state);
    assign o_cpu_reset = w_ctrl.cpu_reset;
    assign o_ProgMode  = w_ctrl.prog_mode;
    assign o_busy      = w_ctrl.busy;
    assign o_Addr_Prog = r_addr;
    assign o_Data_Prog = r_data;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a frame-level reference model
// that rebuilds words from the byte queue of the current frame.
module tb_prog_loader;

    localparam int         TimeoutCyc = 50;
    localparam int         RstCyc     = 1;
    localparam logic [7:0] Sync       = 8'hA5;

    localparam int MIdle    = 0;
    localparam int MHdr     = 1;
    localparam int MData    = 2;
    localparam int MRelease = 3;
    localparam int MRun     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        prog_mode;
    logic        cpu_reset;
    logic [7:0]  addr_prog;
    logic [31:0] data_prog;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    prog_loader #(
        .SYNC_BYTE  (Sync),
        .TIMEOUT    (TimeoutCyc),
        .RST_CYCLES (RstCyc)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_valid  (rx_valid),
        .i_rx_byte   (rx_byte),
        .o_ProgMode  (prog_mode),
        .o_cpu_reset (cpu_reset),
        .o_Addr_Prog (addr_prog),
        .o_Data_Prog (data_prog),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_mode;
    logic [7:0]  m_bytes[$];
    int          m_words;
    int          m_idle;
    int          m_pend;
    int          m_rel;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic        m_err;
    logic        m_done;

    logic [31:0] fixed_words[9] = '{32'h10600DDE, 32'h10400000, 32'h20420001,
                                    32'h00000000, 32'hAC020004, 32'h8C030004,
                                    32'h00431020, 32'h1000FFFF, 32'hFC000008};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step(input logic r, input logic v, input logic [7:0] b);
        bit was_last;
        m_done = 1'b0;
        if (r) begin
            m_mode = MIdle;
            m_addr = 8'h00;
            m_data = 32'h0;
            m_err  = 1'b0;
            m_bytes.delete();
            m_pend = -1;
            m_idle = 0;
            m_rel  = 0;
            return;
        end
        case (m_mode)
            MIdle: if (v && b == Sync) begin
                m_mode = MHdr;
                m_err  = 1'b0;
                m_idle = 0;
            end
            MHdr: begin
                if (v) begin
                    m_words = int'(b) + 1;
                    m_bytes.delete();
                    m_pend = -1;
                    m_idle = 0;
                    m_mode = MData;
                end else begin
                    m_idle++;
                    if (m_idle == TimeoutCyc) begin
                        m_mode = MIdle;
                        m_err  = 1'b1;
                    end
                end
            end
            MData: begin
                was_last = 1'b0;
                if (m_pend >= 0) begin
                    m_addr = 8'(m_pend);
                    m_data = {m_bytes[4*m_pend], m_bytes[4*m_pend+1],
                              m_bytes[4*m_pend+2], m_bytes[4*m_pend+3]};
                    if (m_pend == m_words - 1) begin
                        m_mode   = MRelease;
                        m_rel    = 0;
                        was_last = 1'b1;
                    end
                    m_pend = -1;
                end
                if (!was_last) begin
                    if (v) begin
                        m_bytes.push_back(b);
                        m_idle = 0;
                        if (m_bytes.size() % 4 == 0) m_pend = m_bytes.size() / 4 - 1;
                    end else begin
                        m_idle++;
                        if (m_idle == TimeoutCyc) begin
                            m_mode = MIdle;
                            m_err  = 1'b1;
                            m_bytes.delete();
                        end
                    end
                end
            end
            MRelease: begin
                m_rel++;
                if (m_rel == RstCyc) begin
                    m_mode = MRun;
                    m_done = 1'b1;
                end
            end
            MRun: if (v && b == Sync) begin
                m_mode = MHdr;
                m_err  = 1'b0;
                m_idle = 0;
            end
            default: ;
        endcase
    endfunction

    task automatic compare_all();
        check("cpu_reset", 32'(cpu_reset), 32'(m_mode != MRun));
        check("prog_mode", 32'(prog_mode), 32'(m_mode == MRelease || m_mode == MRun));
        check("busy",      32'(busy),      32'(m_mode == MHdr || m_mode == MData));
        check("addr",      32'(addr_prog), 32'(m_addr));
        check("data",      data_prog,      m_data);
        check("done",      32'(done),      32'(m_done));
        check("error",     32'(error),     32'(m_err));
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        rst      = r;
        rx_valid = v;
        rx_byte  = b;
        @(posedge clk);
        model_step(r, v, b);
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        compare_all();
    endtask

    function automatic int rgap(input int maxg);
        return (maxg == 0) ? 0 : int'($urandom_range(maxg, 0));
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxg);
        for (int i = 3; i >= 0; i--) send(w[8*i +: 8], rgap(maxg));
    endtask

    task automatic send_frame(input logic [7:0] cnt, input int maxg, input bit with_sync);
        if (with_sync) send(Sync, rgap(maxg));
        send(cnt, rgap(maxg));
        for (int i = 0; i <= int'(cnt); i++) send_word($urandom, maxg);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);

        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_prog_mode", 32'(prog_mode), 32'd0);
        check("rst_addr",      32'(addr_prog), 32'd0);
        check("rst_data",      data_prog,      32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_error",     32'(error),     32'd0);

        // Noise in IDLE
        send(8'h00, 0);
        send(8'hFF, 1);
        idle(2);
        check("noise_busy", 32'(busy), 32'd0);

        // Full 9-word load, back to back
        send(Sync, 0);
        send(8'h08, 0);
        foreach (fixed_words[i]) send_word(fixed_words[i], 0);
        idle(3);
        check("full_addr",      32'(addr_prog), 32'd8);
        check("full_data",      data_prog,      32'hFC000008);
        check("full_cpu_reset", 32'(cpu_reset), 32'd0);
        check("full_prog_mode", 32'(prog_mode), 32'd1);

        // Restart from RUN with a single-word frame
        send(Sync, 2);
        check("restart_prog_mode", 32'(prog_mode), 32'd0);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        send(8'h00, 0);
        send_word(32'h12345678, 0);
        idle(1);
        check("single_addr",      32'(addr_prog), 32'd0);
        check("single_data",      data_prog,      32'h12345678);
        check("single_release",   32'({cpu_reset, prog_mode}), 32'b11);
        idle(1);
        check("single_cpu_reset", 32'(cpu_reset), 32'd0);
        check("single_done",      32'(done),      32'd1);

        // Random frames with random gaps
        for (int f = 0; f < 6; f++) begin
            send_frame(8'($urandom_range(6, 0)), 3, 1'b1);
            idle(2 + rgap(3));
        end

        // Data-phase timeout
        send(Sync, 0);
        send(8'h01, 0);
        send(8'h11, 0);
        send(8'h22, 1);
        send(8'h33, 0);
        idle(TimeoutCyc - 1);
        check("to_still_busy", 32'(busy), 32'd1);
        idle(1);
        check("to_error",     32'(error),     32'd1);
        check("to_busy",      32'(busy),      32'd0);
        check("to_cpu_reset", 32'(cpu_reset), 32'd1);
        send(Sync, 3);
        check("to_error_clr", 32'(error), 32'd0);
        send_frame(8'h02, 2, 1'b0);
        idle(3);

        // Header-phase timeout
        send(Sync, 0);
        idle(TimeoutCyc + 5);
        check("hdr_to_error", 32'(error), 32'd1);

        // Count byte equal to the sync value: 166 words
        send(Sync, 1);
        send(8'hA5, 0);
        for (int i = 0; i < 166; i++) send_word($urandom, 2);
        idle(3);
        check("a5_addr",      32'(addr_prog), 32'd165);
        check("a5_cpu_reset", 32'(cpu_reset), 32'd0);

        // Reset during DATA
        send(Sync, 0);
        send(8'h03, 0);
        send_word($urandom, 1);
        send(8'hA5, 0);
        send(8'h5A, 0);
        step(1'b1, 1'b0, 8'h00);
        check("mid_rst_addr",      32'(addr_prog), 32'd0);
        check("mid_rst_data",      data_prog,      32'd0);
        check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_rst_prog_mode", 32'(prog_mode), 32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        idle(2);
        send_frame(8'h04, 3, 1'b1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
